// File: rtl/cx_switch_pkg.sv
// Shared constants and the order-FIFO entry type for the CX switch.
package cx_switch_pkg;

  localparam int CX_ID_MAX_W = 4;

  localparam logic [3:0] CX_ST_OK     = 4'h0;
  localparam logic [3:0] CX_ST_ERR_ID = 4'h2;

  // One entry per accepted request: which CXU owes the answer, or a
  // locally generated error for an id that no CXU owns.
  typedef struct packed {
    logic                   err;
    logic [CX_ID_MAX_W-1:0] id;
  } cx_order_t;

endpackage

// File: rtl/cx_order_fifo.sv
// Synchronous FIFO that remembers request order; head entry is always visible.
module cx_order_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [WIDTH-1:0]       head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [PTR_W-1:0] LAST    = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [CNT_W-1:0] r_cnt;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_cnt == DEPTH_C);
  assign empty     = (r_cnt == '0);
  assign count     = r_cnt;
  assign head      = r_mem[r_rd];
  // Full is judged on the registered count, so a same-cycle pop never frees a slot.
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  // Pointer and occupancy bookkeeping; pointers wrap at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) r_wr <= (r_wr == LAST) ? '0 : r_wr + PTR_W'(1);
      if (w_do_pop)  r_rd <= (r_rd == LAST) ? '0 : r_rd + PTR_W'(1);
      if (w_do_push && !w_do_pop)      r_cnt <= r_cnt + CNT_W'(1);
      else if (!w_do_push && w_do_pop) r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Storage carries no reset; occupancy alone says what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr] <= din;
  end

endmodule

// File: rtl/cx_switch_ooo.sv
// CX switch: dispatches Ibex requests to NUM_CXU units and returns the
// answers strictly in request order, whatever order the units finish in.
module cx_switch_ooo
  import cx_switch_pkg::*;
#(
  parameter int NUM_CXU = 4,
  parameter int DATA_W  = 32,
  parameter int STATE_W = 2,
  parameter int MAX_OUT = 4,
  localparam int CXU_ID_W = (NUM_CXU > 1) ? $clog2(NUM_CXU) : 1,
  localparam int OUT_W    = $clog2(MAX_OUT) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cx_req_valid,
  output logic                      cx_req_ready,
  input  logic [CXU_ID_W-1:0]       cx_cxu_id,
  input  logic [STATE_W-1:0]        cx_state_id,
  input  logic [DATA_W-1:0]         cx_req_data0,
  input  logic [DATA_W-1:0]         cx_req_data1,
  output logic                      cx_resp_valid,
  input  logic                      cx_resp_ready,
  output logic                      cx_resp_state,
  output logic [3:0]                cx_resp_status,
  output logic [DATA_W-1:0]         cx_resp_data,
  output logic [NUM_CXU-1:0]        cxu_req_valid,
  input  logic [NUM_CXU-1:0]        cxu_req_ready,
  output logic [DATA_W-1:0]         cxu_data0_o,
  output logic [DATA_W-1:0]         cxu_data1_o,
  output logic [STATE_W-1:0]        cxu_state_id_o,
  input  logic [NUM_CXU-1:0]        cxu_resp_valid,
  output logic [NUM_CXU-1:0]        cxu_resp_ready,
  input  logic [NUM_CXU*DATA_W-1:0] cxu_resp_data,
  input  logic [NUM_CXU*4-1:0]      cxu_resp_status,
  input  logic [NUM_CXU-1:0]        cxu_resp_state,
  output logic [OUT_W-1:0]          outstanding
);

  localparam logic [CXU_ID_W:0] NUM_CXU_C = (CXU_ID_W + 1)'(NUM_CXU);

  logic              w_id_ok;
  logic              w_sel_req_ready;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_can_retire;
  logic              w_head_valid;
  logic [DATA_W-1:0] w_head_data;
  logic [3:0]        w_head_status;
  logic              w_head_state;
  logic [OUT_W-1:0]  w_count;
  cx_order_t         w_push_entry;
  cx_order_t         w_head;

  logic              r_resp_valid;
  logic              r_resp_state;
  logic [3:0]        r_resp_status;
  logic [DATA_W-1:0] r_resp_data;

  assign cxu_data0_o    = cx_req_data0;
  assign cxu_data1_o    = cx_req_data1;
  assign cxu_state_id_o = cx_state_id;

  // Zero-latency dispatch decode; bad ids are accepted but reach no CXU.
  always_comb begin
    w_id_ok         = ({1'b0, cx_cxu_id} < NUM_CXU_C);
    w_sel_req_ready = 1'b0;
    cxu_req_valid   = '0;
    for (int k = 0; k < NUM_CXU; k++) begin
      if (cx_cxu_id == CXU_ID_W'(k)) begin
        w_sel_req_ready  = cxu_req_ready[k];
        cxu_req_valid[k] = cx_req_valid & ~w_full & ~rst;
      end
    end
    cx_req_ready     = ~rst & ~w_full & (~w_id_ok | w_sel_req_ready);
    w_push           = cx_req_valid & cx_req_ready;
    w_push_entry.err = ~w_id_ok;
    w_push_entry.id  = CX_ID_MAX_W'(cx_cxu_id);
  end

  cx_order_fifo #(
    .WIDTH ($bits(cx_order_t)),
    .DEPTH (MAX_OUT)
  ) u_order_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .din   (w_push_entry),
    .pop   (w_pop),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count),
    .head  (w_head)
  );

  // Retire mux: only the CXU at the head of the order FIFO may be acked.
  always_comb begin
    w_can_retire   = ~rst & ~w_empty & (~r_resp_valid | cx_resp_ready);
    w_head_valid   = 1'b0;
    w_head_data    = '0;
    w_head_status  = CX_ST_ERR_ID;
    w_head_state   = 1'b0;
    cxu_resp_ready = '0;
    if (w_head.err) begin
      w_head_valid = 1'b1;
    end else begin
      for (int k = 0; k < NUM_CXU; k++) begin
        if (w_head.id == CX_ID_MAX_W'(k)) begin
          w_head_valid      = cxu_resp_valid[k];
          w_head_data       = cxu_resp_data[k*DATA_W +: DATA_W];
          w_head_status     = cxu_resp_status[k*4 +: 4];
          w_head_state      = cxu_resp_state[k];
          cxu_resp_ready[k] = w_can_retire & cxu_resp_valid[k];
        end
      end
    end
    w_pop = w_can_retire & w_head_valid;
  end

  // Output register toward Ibex; holds until the core takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_resp_valid  <= 1'b0;
      r_resp_state  <= 1'b0;
      r_resp_status <= CX_ST_OK;
      r_resp_data   <= '0;
    end else if (w_pop) begin
      r_resp_valid  <= 1'b1;
      r_resp_state  <= w_head_state;
      r_resp_status <= w_head_status;
      r_resp_data   <= w_head_data;
    end else if (cx_resp_ready) begin
      r_resp_valid  <= 1'b0;
    end
  end

  assign cx_resp_valid  = r_resp_valid;
  assign cx_resp_state  = r_resp_state;
  assign cx_resp_status = r_resp_status;
  assign cx_resp_data   = r_resp_data;
  assign outstanding    = w_count + OUT_W'(r_resp_valid);

endmodule

// File: tb/tb_cx_switch_ooo.sv
// Directed bench for cx_switch_ooo with three adder-style CXU models (NUM_CXU=3).
module tb_cx_switch_ooo;

  localparam int N  = 3;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cx_req_valid;
  logic          cx_req_ready;
  logic [1:0]    cx_cxu_id;
  logic [1:0]    cx_state_id;
  logic [DW-1:0] cx_req_data0;
  logic [DW-1:0] cx_req_data1;
  logic          cx_resp_valid;
  logic          cx_resp_ready;
  logic          cx_resp_state;
  logic [3:0]    cx_resp_status;
  logic [DW-1:0] cx_resp_data;
  logic [N-1:0]  cxu_req_valid;
  logic [N-1:0]  cxu_req_ready;
  logic [DW-1:0] cxu_data0_o;
  logic [DW-1:0] cxu_data1_o;
  logic [1:0]    cxu_state_id_o;
  logic [N-1:0]  cxu_resp_valid;
  logic [N-1:0]  cxu_resp_ready;
  logic [N*DW-1:0] cxu_resp_data;
  logic [N*4-1:0]  cxu_resp_status;
  logic [N-1:0]  cxu_resp_state;
  logic [2:0]    outstanding;

  logic [N-1:0]  hold;
  int            lat [N];
  int            cyc = 0;
  int            n_chk = 0;
  int            n_err = 0;
  int            n_got = 0;
  logic [DW-1:0] got_data [64];
  logic [3:0]    got_st   [64];
  logic          got_state[64];
  logic [N-1:0]  last_vld;
  int            base;
  int            s0;
  int            h0;

  always #5 clk = ~clk;

  cx_switch_ooo #(
    .NUM_CXU (N),
    .DATA_W  (DW),
    .STATE_W (2),
    .MAX_OUT (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cx_req_valid    (cx_req_valid),
    .cx_req_ready    (cx_req_ready),
    .cx_cxu_id       (cx_cxu_id),
    .cx_state_id     (cx_state_id),
    .cx_req_data0    (cx_req_data0),
    .cx_req_data1    (cx_req_data1),
    .cx_resp_valid   (cx_resp_valid),
    .cx_resp_ready   (cx_resp_ready),
    .cx_resp_state   (cx_resp_state),
    .cx_resp_status  (cx_resp_status),
    .cx_resp_data    (cx_resp_data),
    .cxu_req_valid   (cxu_req_valid),
    .cxu_req_ready   (cxu_req_ready),
    .cxu_data0_o     (cxu_data0_o),
    .cxu_data1_o     (cxu_data1_o),
    .cxu_state_id_o  (cxu_state_id_o),
    .cxu_resp_valid  (cxu_resp_valid),
    .cxu_resp_ready  (cxu_resp_ready),
    .cxu_resp_data   (cxu_resp_data),
    .cxu_resp_status (cxu_resp_status),
    .cxu_resp_state  (cxu_resp_state),
    .outstanding     (outstanding)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // CXU k returns d0 + d1 + 256*k after lat[k] cycles; state bit = k[0]; hold[k] masks the answer.
  assign cxu_resp_status = '0;
  for (genvar k = 0; k < N; k++) begin : g_cxu
    logic [DW-1:0] res [8];
    int            due [8];
    logic [2:0]    wp;
    logic [2:0]    rp;
    int            hs_cyc;
    int            hs_cnt;
    int            stall_cnt;
    always @(posedge clk) begin
      if (rst) begin
        wp <= '0; rp <= '0; hs_cnt <= 0; stall_cnt <= 0; hs_cyc <= 0;
      end else begin
        if (cxu_req_valid[k] && cxu_req_ready[k]) begin
          res[wp] <= cxu_data0_o + cxu_data1_o + 32'(k * 256);
          due[wp] <= cyc + lat[k];
          wp      <= wp + 3'd1;
        end
        if (cxu_resp_valid[k] && cxu_resp_ready[k]) begin
          rp     <= rp + 3'd1;
          hs_cyc <= cyc;
          hs_cnt <= hs_cnt + 1;
        end
        if (cxu_resp_valid[k] && !cxu_resp_ready[k]) stall_cnt <= stall_cnt + 1;
      end
    end
    assign cxu_resp_valid[k]         = (wp != rp) && (cyc >= due[rp]) && !hold[k];
    assign cxu_resp_data[k*DW +: DW] = res[rp];
    assign cxu_resp_state[k]         = 1'(k & 1);
  end

  // Response log toward Ibex
  always @(posedge clk) begin
    if (!rst && cx_resp_valid && cx_resp_ready) begin
      got_data[n_got]  <= cx_resp_data;
      got_st[n_got]    <= cx_resp_status;
      got_state[n_got] <= cx_resp_state;
      n_got            <= n_got + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input string tag, input logic [1:0] id, input logic [31:0] d0, input logic [31:0] d1);
    bit ok;
    ok           = 1'b0;
    cx_req_valid = 1'b1;
    cx_cxu_id    = id;
    cx_req_data0 = d0;
    cx_req_data1 = d1;
    for (int i = 0; i < 50 && !ok; i++) begin
      #1;
      last_vld = cxu_req_valid;
      if (cx_req_ready) ok = 1'b1;
      @(negedge clk);
    end
    cx_req_valid = 1'b0;
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_got(input int target, input string tag);
    for (int i = 0; i < 100 && n_got < target; i++) @(negedge clk);
    check(tag, 32'(n_got >= target), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cx_req_valid  = 1'b0;
    cx_cxu_id     = '0;
    cx_state_id   = '0;
    cx_req_data0  = '0;
    cx_req_data1  = '0;
    cx_resp_ready = 1'b1;
    cxu_req_ready = '1;
    hold          = '0;
    for (int k = 0; k < N; k++) lat[k] = 1;
    last_vld      = '0;

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    cx_req_valid = 1'b1;
    #1;
    check("rst_req_vld", 32'(cxu_req_valid), 32'd0);
    check("rst_req_rdy", 32'(cx_req_ready), 32'd0);
    cx_req_valid = 1'b0;
    check("rst_outst", 32'(outstanding), 32'd0);
    check("rst_resp_vld", 32'(cx_resp_valid), 32'd0);
    check("rst_resp_data", cx_resp_data, 32'd0);
    check("rst_resp_st", 32'(cx_resp_status), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1 single request
    lat[0] = 3;
    base = n_got;
    cx_state_id = 2'd2;
    #1;
    check("t1_state_bcast", 32'(cxu_state_id_o), 32'd2);
    send("t1_acc", 2'd0, 32'd5, 32'd1);
    check("t1_req_onehot", 32'(last_vld), 32'b001);
    check("t1_outst", 32'(outstanding), 32'd1);
    wait_got(base + 1, "t1_resp_arrive");
    check("t1_data", got_data[base], 32'd6);
    check("t1_status", 32'(got_st[base]), 32'd0);
    repeat (5) @(negedge clk);
    check("t1_one_pulse", 32'(n_got), 32'(base + 1));
    check("t1_outst_end", 32'(outstanding), 32'd0);

    // 2 reorder: slow CXU1 then fast CXU0
    lat[0] = 1;
    lat[1] = 10;
    base = n_got;
    s0 = g_cxu[0].stall_cnt;
    send("t2_acc1", 2'd1, 32'd10, 32'd20);
    send("t2_acc0", 2'd0, 32'd3, 32'd4);
    wait_got(base + 2, "t2_resp_arrive");
    check("t2_first_data", got_data[base], 32'd286);
    check("t2_first_state", 32'(got_state[base]), 32'd1);
    check("t2_second_data", got_data[base + 1], 32'd7);
    check("t2_second_state", 32'(got_state[base + 1]), 32'd0);
    check("t2_ack_order", 32'(g_cxu[0].hs_cyc > g_cxu[1].hs_cyc), 32'd1);
    check("t2_cxu0_stalled", 32'(g_cxu[0].stall_cnt > s0), 32'd1);
    lat[1] = 1;

    // 3 full order FIFO
    hold[0] = 1'b1;
    base = n_got;
    for (int i = 1; i <= 4; i++) send("t3_acc", 2'd0, 32'(i), 32'd0);
    check("t3_outst_full", 32'(outstanding), 32'd4);
    cx_req_valid = 1'b1;
    cx_cxu_id    = 2'd0;
    cx_req_data0 = 32'd100;
    cx_req_data1 = 32'd0;
    #1;
    check("t3_full_rdy", 32'(cx_req_ready), 32'd0);
    check("t3_full_vld", 32'(cxu_req_valid), 32'd0);
    @(negedge clk);
    #1;
    check("t3_full_rdy2", 32'(cx_req_ready), 32'd0);
    hold[0] = 1'b0;
    #1;
    check("t3_no_bypass", 32'(cx_req_ready), 32'd0);
    @(negedge clk);
    #1;
    check("t3_rdy_after_pop", 32'(cx_req_ready), 32'd1);
    @(negedge clk);
    cx_req_valid = 1'b0;
    wait_got(base + 5, "t3_resp_arrive");
    check("t3_first", got_data[base], 32'd1);
    check("t3_fourth", got_data[base + 3], 32'd4);
    check("t3_fifth", got_data[base + 4], 32'd100);
    repeat (3) @(negedge clk);
    check("t3_outst_end", 32'(outstanding), 32'd0);

    // 4 bad id between two good ones
    base = n_got;
    send("t4_acc0", 2'd0, 32'd1, 32'd1);
    send("t4_acc_bad", 2'd3, 32'd7, 32'd7);
    check("t4_bad_vld", 32'(last_vld), 32'd0);
    send("t4_acc1", 2'd1, 32'd2, 32'd2);
    check("t4_req_onehot", 32'(last_vld), 32'b010);
    wait_got(base + 3, "t4_resp_arrive");
    check("t4_d0", got_data[base], 32'd2);
    check("t4_s0", 32'(got_st[base]), 32'd0);
    check("t4_bad_data", got_data[base + 1], 32'd0);
    check("t4_bad_st", 32'(got_st[base + 1]), 32'h2);
    check("t4_bad_state", 32'(got_state[base + 1]), 32'd0);
    check("t4_d2", got_data[base + 2], 32'd260);
    check("t4_s2", 32'(got_st[base + 2]), 32'd0);

    // 5 backpressure from Ibex
    cx_resp_ready = 1'b0;
    base = n_got;
    h0 = g_cxu[0].hs_cnt;
    send("t5_acc_a", 2'd0, 32'd1, 32'd2);
    send("t5_acc_b", 2'd0, 32'd3, 32'd4);
    repeat (5) @(negedge clk);
    check("t5_hold_vld", 32'(cx_resp_valid), 32'd1);
    check("t5_hold_data", cx_resp_data, 32'd3);
    check("t5_outst", 32'(outstanding), 32'd2);
    check("t5_no_ack", 32'(cxu_resp_ready), 32'd0);
    check("t5_ack_count", 32'(g_cxu[0].hs_cnt), 32'(h0 + 1));
    cx_resp_ready = 1'b1;
    @(negedge clk);
    check("t5_drain1_cnt", 32'(n_got), 32'(base + 1));
    check("t5_drain1_data", got_data[base], 32'd3);
    check("t5_next_data", cx_resp_data, 32'd7);
    check("t5_next_vld", 32'(cx_resp_valid), 32'd1);
    @(negedge clk);
    check("t5_drain2_cnt", 32'(n_got), 32'(base + 2));
    check("t5_drain2_data", got_data[base + 1], 32'd7);
    check("t5_empty_vld", 32'(cx_resp_valid), 32'd0);

    // 6 reset with requests in flight
    hold = '1;
    send("t6_acc_a", 2'd0, 32'd1, 32'd1);
    send("t6_acc_b", 2'd1, 32'd1, 32'd1);
    send("t6_acc_c", 2'd0, 32'd1, 32'd1);
    check("t6_outst_pre", 32'(outstanding), 32'd3);
    rst          = 1'b1;
    cx_req_valid = 1'b1;
    cx_cxu_id    = 2'd0;
    @(negedge clk);
    #1;
    check("t6_outst", 32'(outstanding), 32'd0);
    check("t6_resp_vld", 32'(cx_resp_valid), 32'd0);
    check("t6_req_vld", 32'(cxu_req_valid), 32'd0);
    cx_req_valid = 1'b0;
    rst          = 1'b0;
    hold         = '0;
    base = n_got;
    repeat (10) @(negedge clk);
    check("t6_no_stale", 32'(n_got), 32'(base));
    check("t6_outst_end", 32'(outstanding), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
